// File: rtl/mula_sequencer.sv
// Multi-cycle MULA sequencer: iterative shift-add unsigned multiply, then adds the
// 2*WIDTH-bit product into the Hi:Lo accumulator while stalling the pipeline.
module mula_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          EARLY_TERM = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_flush,
  input  logic             i_clear_acc,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StMul, StAcc, StDone} state_e;

  state_e               r_state, w_state_d;
  logic [2*WIDTH-1:0]   r_areg, w_areg_d;
  logic [WIDTH-1:0]     r_breg, w_breg_d;
  logic [2*WIDTH-1:0]   r_prod, w_prod_d;
  logic [CntW-1:0]      r_cnt, w_cnt_d;
  logic [2*WIDTH-1:0]   r_acc, w_acc_d;
  logic [WIDTH-1:0]     w_breg_shr;
  logic                 w_mul_last;

  assign w_breg_shr = r_breg >> 1;
  // Last iteration: counter exhausted, or no multiplier bits left to consume.
  assign w_mul_last = (r_cnt == CntW'(WIDTH - 1)) || (EARLY_TERM && (w_breg_shr == '0));

  always_comb begin
    w_state_d = r_state;
    w_areg_d  = r_areg;
    w_breg_d  = r_breg;
    w_prod_d  = r_prod;
    w_cnt_d   = r_cnt;
    w_acc_d   = r_acc;
    o_stall   = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;

    unique case (r_state)
      StIdle: begin
        o_stall = i_start && !i_flush;
        if (i_clear_acc) begin
          w_acc_d = '0;
        end
        if (i_start && !i_flush) begin
          w_areg_d  = {{WIDTH{1'b0}}, i_op_a};
          w_breg_d  = i_op_b;
          w_prod_d  = '0;
          w_cnt_d   = '0;
          w_state_d = StMul;
        end
      end
      StMul: begin
        o_stall = 1'b1;
        o_busy  = 1'b1;
        if (i_flush) begin
          w_state_d = StIdle;
        end else begin
          if (r_breg[0]) begin
            w_prod_d = r_prod + r_areg;
          end
          w_areg_d = r_areg << 1;
          w_breg_d = w_breg_shr;
          w_cnt_d  = r_cnt + 1'b1;
          if (w_mul_last) begin
            w_state_d = StAcc;
          end
        end
      end
      StAcc: begin
        o_stall = 1'b1;
        o_busy  = 1'b1;
        if (i_flush) begin
          w_state_d = StIdle;
        end else begin
          w_acc_d   = r_acc + r_prod;
          w_state_d = StDone;
        end
      end
      StDone: begin
        // The MULA instruction still sits in EX here, so Start is not a new request.
        o_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_areg  <= '0;
      r_breg  <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_d;
      r_areg  <= w_areg_d;
      r_breg  <= w_breg_d;
      r_prod  <= w_prod_d;
      r_cnt   <= w_cnt_d;
      r_acc   <= w_acc_d;
    end
  end

  assign o_hi = r_acc[2*WIDTH-1:WIDTH];
  assign o_lo = r_acc[WIDTH-1:0];

endmodule

// File: tb/tb_mula_sequencer.sv
// Scoreboarded bench for mula_sequencer: a driver pushes expected accumulator values and
// Done cycles, a negedge monitor pops and compares on every Done pulse.
module tb_mula_sequencer;

  localparam int unsigned W  = 32;
  localparam bit          ET = 1'b1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, flush, clear_acc;
  logic [W-1:0] op_a, op_b;
  logic         stall, busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [63:0] acc;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model_acc;
  int          cyc;
  int          compared;
  int          mismatched;

  mula_sequencer #(
    .WIDTH      (W),
    .EARLY_TERM (ET)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .i_flush     (flush),
    .i_clear_acc (clear_acc),
    .o_stall     (stall),
    .o_busy      (busy),
    .o_done      (done),
    .o_hi        (hi),
    .o_lo        (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Multiply cycle count from the multiplier's highest set bit.
  function automatic int mul_cycles(input logic [W-1:0] b);
    int m;
    if (!ET) return W;
    m = 1;
    for (int i = 0; i < W; i++) if (b[i]) m = i + 1;
    return m;
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("acc_at_done", {hi, lo}, e.acc);
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called #1 after a rising edge with the DUT in IDLE; returns likewise.
  task automatic mula(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit clr_issue, input bit clr_mul);
    int   c0;
    bit   got;
    bit   bad;
    exp_t e;
    op_a      = a;
    op_b      = b;
    start     = 1'b1;
    clear_acc = clr_issue;
    @(negedge clk);
    chk("issue_stall", 64'(stall), 64'(1));
    @(posedge clk);
    #1;
    c0        = cyc;
    clear_acc = clr_mul;
    op_a      = $urandom;
    op_b      = $urandom;
    if (clr_issue) model_acc = '0;
    model_acc = model_acc + (64'(a) * 64'(b));
    e.acc = model_acc;
    e.cyc = c0 + mul_cycles(b) + 1;
    sb_q.push_back(e);
    got = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 2 * W + 8; n++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk("done_stall_busy", {62'(0), stall, busy}, 64'(0));
        break;
      end else if (!stall || !busy) begin
        bad = 1'b1;
      end
    end
    chk("done_seen", 64'(got), 64'(1));
    chk("stall_busy_during_op", 64'(bad), 64'(0));
    // Start stays high through DONE; it must not launch a second operation.
    @(posedge clk);
    #1;
    start     = 1'b0;
    clear_acc = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    model_acc  = '0;
    rst        = 1'b1;
    start      = 1'b0;
    flush      = 1'b0;
    clear_acc  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {61'(0), stall, busy, done}, 64'(0));
    chk("reset_acc", {hi, lo}, 64'(0));
    @(posedge clk);
    #1;

    // Directed: basic, full-width, wrap-around, OpB=0.
    mula(32'd3, 32'd5, 1'b0, 1'b0);
    chk("lo_3x5", 64'(lo), 64'(15));
    mula(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("acc_full", {hi, lo}, 64'hFFFF_FFFE_0000_0010);
    mula(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    mula(32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("acc_all_ones", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    mula(32'h1_0000, 32'h1_0000, 1'b0, 1'b0);
    chk("acc_wrap", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    mula(32'h1234_5678, 32'd0, 1'b0, 1'b0);
    chk("acc_opb_zero", {hi, lo}, 64'h0000_0000_FFFF_FFFF);

    // Flush in the third MUL cycle.
    op_a  = 32'd7;
    op_b  = 32'hFF;
    start = 1'b1;
    idle_cycles(3);
    flush = 1'b1;
    idle_cycles(1);
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("flush_mul_idle", {61'(0), stall, busy, done}, 64'(0));
    chk("flush_mul_acc", {hi, lo}, model_acc);
    idle_cycles(40);

    // Flush in IDLE blocks Start.
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", 64'(stall), 64'(0));
    idle_cycles(1);
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", 64'(busy), 64'(0));
    idle_cycles(5);

    // ClearAcc during MUL is ignored; ClearAcc with Start accumulates onto zero.
    mula(32'h0000_0101, 32'h0000_F00F, 1'b0, 1'b1);
    chk("clear_in_mul_ignored", {hi, lo}, model_acc);
    mula(32'd2, 32'd3, 1'b1, 1'b0);
    chk("clear_start_lo", 64'(lo), 64'(6));
    chk("clear_start_hi", 64'(hi), 64'(0));

    // Reset asserted during ACC.
    op_a  = 32'd5;
    op_b  = 32'd1;
    start = 1'b1;
    idle_cycles(2);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("in_acc_busy", 64'(busy), 64'(1));
    idle_cycles(1);
    rst = 1'b0;
    model_acc = '0;
    @(negedge clk);
    chk("reset_acc_outputs", {61'(0), stall, busy, done}, 64'(0));
    chk("reset_acc_value", {hi, lo}, 64'(0));
    idle_cycles(5);

    // Randomized operations, back to back.
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      mula(a, b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    chk("final_acc", {hi, lo}, model_acc);

    idle_cycles(10);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
